// File: rtl/mem_access_wb.sv
// MEM stage with a data-memory handshake FSM (IDLE/REQ/DONE), wait-cycle timeout,
// alignment fault detection and the MEM/WB pipeline register.
module mem_access_wb #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_alures,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_Rw,
  input  logic [1:0]  i_M,
  input  logic        i_WB,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata,
  input  logic        i_dm_ack,
  output logic        o_stall,
  output logic [31:0] o_alures,
  output logic [31:0] o_memdata,
  output logic [4:0]  o_Rw,
  output logic        o_WB,
  output logic        o_exc,
  output logic [1:0]  o_state
);

  // Memory handshake: o_dm_req/o_dm_we/o_dm_addr/o_dm_wdata are held stable from
  // REQ entry until the cycle in which i_dm_ack=1 (or the timeout), then dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        fault, fault_nx;
  logic [31:0] cap, cap_nx;
  logic        req_nx, we_nx;
  logic [31:0] addr_nx, wdata_nx;
  logic        op_valid, misaligned;
  logic        wb_fault;
  logic [31:0] wb_memdata;

  assign op_valid   = (i_M != 2'b00);
  assign misaligned = (i_alures[1:0] != 2'b00);
  assign o_state    = state;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    fault_nx   = fault;
    cap_nx     = cap;
    req_nx     = o_dm_req;
    we_nx      = o_dm_we;
    addr_nx    = o_dm_addr;
    wdata_nx   = o_dm_wdata;
    o_stall    = 1'b0;
    wb_fault   = 1'b0;
    wb_memdata = 32'd0;
    case (state)
      IDLE: begin
        if (op_valid && !misaligned) begin
          o_stall  = 1'b1;
          state_nx = REQ;
          req_nx   = 1'b1;
          we_nx    = (i_M == 2'b01);
          addr_nx  = i_alures;
          wdata_nx = i_busB;
          cnt_nx   = 4'd0;
          fault_nx = 1'b0;
          cap_nx   = 32'd0;
        end else if (op_valid) begin
          wb_fault = 1'b1;
        end
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_dm_ack) begin
          cap_nx   = o_dm_we ? 32'd0 : i_dm_rdata;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          fault_nx = 1'b0;
          state_nx = DONE;
        end else if (cnt == TO_LAST) begin
          // Abort: the memory never answered; the entry retires as a fault.
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          fault_nx = 1'b1;
          cap_nx   = 32'd0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx   = IDLE;
        wb_fault   = fault;
        wb_memdata = cap;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      fault      <= 1'b0;
      cap        <= 32'd0;
      o_dm_req   <= 1'b0;
      o_dm_we    <= 1'b0;
      o_dm_addr  <= 32'd0;
      o_dm_wdata <= 32'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      fault      <= fault_nx;
      cap        <= cap_nx;
      o_dm_req   <= req_nx;
      o_dm_we    <= we_nx;
      o_dm_addr  <= addr_nx;
      o_dm_wdata <= wdata_nx;
    end
  end

  // MEM/WB register: a bubble while stalled (data fields held), otherwise the live entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alures  <= 32'd0;
      o_memdata <= 32'd0;
      o_Rw      <= 5'd0;
      o_WB      <= 1'b0;
      o_exc     <= 1'b0;
    end else if (o_stall) begin
      o_Rw  <= 5'd0;
      o_WB  <= 1'b0;
      o_exc <= 1'b0;
    end else begin
      o_alures  <= i_alures;
      o_memdata <= wb_memdata;
      o_Rw      <= i_Rw;
      o_WB      <= i_WB & ~wb_fault;
      o_exc     <= wb_fault;
    end
  end

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: driver tasks push expected MEM/WB entries,
// an independent monitor pops and compares every retired entry.
module tb_mem_access_wb;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_alures;
  logic [31:0] i_busB;
  logic [4:0]  i_Rw;
  logic [1:0]  i_M;
  logic        i_WB;
  logic        o_dm_req;
  logic        o_dm_we;
  logic [31:0] o_dm_addr;
  logic [31:0] o_dm_wdata;
  logic [31:0] i_dm_rdata;
  logic        i_dm_ack;
  logic        o_stall;
  logic [31:0] o_alures;
  logic [31:0] o_memdata;
  logic [4:0]  o_Rw;
  logic        o_WB;
  logic        o_exc;
  logic [1:0]  o_state;

  int vectors = 0;
  int miscompares = 0;
  logic [70:0] exp_q[$];

  mem_access_wb #(.TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_alures(i_alures), .i_busB(i_busB),
    .i_Rw(i_Rw), .i_M(i_M), .i_WB(i_WB), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
    .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata),
    .i_dm_ack(i_dm_ack), .o_stall(o_stall), .o_alures(o_alures),
    .o_memdata(o_memdata), .o_Rw(o_Rw), .o_WB(o_WB), .o_exc(o_exc),
    .o_state(o_state)
  );

  // Clock / watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [70:0] pack(logic [31:0] a, logic [31:0] d,
                                       logic [4:0] rw, logic wb, logic exc);
    return {a, d, rw, wb, exc};
  endfunction

  task automatic check(string name, logic [70:0] act, logic [70:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every retiring MEM/WB entry (write-back or fault) is scored.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_WB || o_exc)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", pack(o_alures, o_memdata, o_Rw, o_WB, o_exc), 71'd0);
      end else begin
        check("memwb_entry", pack(o_alures, o_memdata, o_Rw, o_WB, o_exc),
              exp_q.pop_front());
      end
    end
  end

  task automatic drive_idle();
    i_M = 2'b00; i_alures = 32'd0; i_busB = 32'd0; i_Rw = 5'd0; i_WB = 1'b0;
    i_dm_ack = 1'b0; i_dm_rdata = 32'd0;
  endtask

  // One EX/MEM op held while stalled; ack_at = REQ cycle that gets the ack (0 = never).
  task automatic run_access(input logic [1:0] m, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [4:0] rw, input logic wb, input int ack_at,
                            input int exp_stall, input int exp_req);
    int stall_cnt = 0;
    int req_cnt = 0;
    bit done = 0;
    logic exp_we;
    exp_we = (m == 2'b01);
    @(negedge i_clk);
    i_M = m; i_alures = addr; i_busB = wdata; i_Rw = rw; i_WB = wb;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (o_dm_req) begin
        req_cnt++;
        check("dm_bus", pack(o_dm_addr, o_dm_wdata, 5'd0, o_dm_we, 1'b0),
              pack(addr, wdata, 5'd0, exp_we, 1'b0));
        if (ack_at != 0 && req_cnt == ack_at) begin
          i_dm_ack = 1'b1; i_dm_rdata = rdata;
        end
      end
      if (!o_stall) done = 1;
      else begin
        stall_cnt++;
        @(negedge i_clk);
        i_dm_ack = 1'b0; i_dm_rdata = 32'hA5A5_A5A5;
      end
    end
    if (!done) check("stall_bound", 71'(stall_cnt), 71'd0);
    check("stall_cycles", 71'(stall_cnt), 71'(exp_stall));
    check("req_cycles", 71'(req_cnt), 71'(exp_req));
    @(negedge i_clk);
    drive_idle();
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge i_clk);
    check("reset_dm", pack(o_dm_addr, o_dm_wdata, 5'd0, o_dm_req, o_dm_we), 71'd0);
    check("reset_memwb", pack(o_alures, o_memdata, o_Rw, o_WB, o_exc), 71'd0);
    check("reset_state", 71'(o_state), 71'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Load, zero-wait ack
    exp_q.push_back(pack(32'h100, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0));
    run_access(2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 1, 2, 1);

    // Store, 3 wait cycles; read data on ack must not reach o_memdata
    exp_q.push_back(pack(32'h44, 32'h0, 5'd7, 1'b1, 1'b0));
    run_access(2'b01, 32'h44, 32'h12345678, 32'hFFFF_FFFF, 5'd7, 1'b1, 4, 5, 4);

    // Misaligned load and misaligned store
    exp_q.push_back(pack(32'h102, 32'h0, 5'd3, 1'b0, 1'b1));
    run_access(2'b10, 32'h102, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 0);
    exp_q.push_back(pack(32'h7, 32'h0, 5'd4, 1'b0, 1'b1));
    run_access(2'b01, 32'h7, 32'h55, 32'h0, 5'd4, 1'b0, 0, 0, 0);

    // Timeout: no ack for 15 REQ cycles
    exp_q.push_back(pack(32'h300, 32'h0, 5'd9, 1'b0, 1'b1));
    run_access(2'b10, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 0, 16, 15);

    // M=11 is a read, one wait cycle
    exp_q.push_back(pack(32'h80, 32'hCAFEF00D, 5'd12, 1'b1, 1'b0));
    run_access(2'b11, 32'h80, 32'h9999, 32'hCAFEF00D, 5'd12, 1'b1, 2, 3, 2);

    // Back-to-back ALU ops, stray ack while idle must be ignored
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_M = 2'b00; i_alures = 32'h1000 + 32'(k * 3); i_Rw = 5'(k + 20); i_WB = 1'b1;
      i_dm_ack = (k == 2); i_dm_rdata = 32'h7777_7777;
      exp_q.push_back(pack(32'h1000 + 32'(k * 3), 32'h0, 5'(k + 20), 1'b1, 1'b0));
      #1;
      check("alu_no_stall", 71'(o_stall), 71'd0);
    end
    @(negedge i_clk);
    drive_idle();

    // Reset in the 2nd REQ cycle, then a late ack after release
    @(negedge i_clk);
    i_M = 2'b10; i_alures = 32'h200; i_Rw = 5'd6; i_WB = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("req2_state", pack(o_dm_addr, 32'h0, 5'd0, o_dm_req, 1'b0),
          pack(32'h200, 32'h0, 5'd0, 1'b1, 1'b0));
    i_rst_n = 1'b0;
    #1;
    check("rst_dm", pack(o_dm_addr, o_dm_wdata, 5'd0, o_dm_req, o_dm_we), 71'd0);
    check("rst_memwb", pack(o_alures, o_memdata, o_Rw, o_WB, o_exc), 71'd0);
    check("rst_state", 71'(o_state), 71'd0);
    drive_idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_dm_ack = 1'b1; i_dm_rdata = 32'hBAD0_BAD0;
    @(negedge i_clk);
    i_dm_ack = 1'b0;
    #1;
    check("late_ack_memwb", pack(o_alures, o_memdata, o_Rw, o_WB, o_exc), 71'd0);
    check("late_ack_dm", pack(32'h0, 32'h0, 5'd0, o_dm_req, o_dm_we), 71'd0);
    check("late_ack_state", 71'(o_state), 71'd0);

    repeat (3) @(negedge i_clk);
    #1;
    check("queue_drained", 71'(exp_q.size()), 71'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
